byte_pair_packer: RTL and testbench

//  - Upstream feeder for the byte-pair combiner stage: packs a serial byte stream into (a,b) byte pairs.
//  - Pairs are buffered in a FWFT FIFO and presented on pair_a/pair_b with a valid/ready handshake.
//  - First accepted byte of a pair is a; second is b.
//  - in_last closes a packet; an odd trailing byte is padded with PAD_BYTE in b.

---
 rtl/byte_pair_pkg.sv | 29 ++
 rtl/byte_pair_fifo.sv | 91 +++++++++
 rtl/byte_pair_packer.sv | 115 +++++++++++
 tb/tb_byte_pair_packer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_pair_pkg.sv
// rtl/byte_pair_pkg.sv - shared types for the byte-pair packer
// Purpose: byte/pair widths, the FIFO entry type and the packer FSM states.
// Ports: none (package).
package byte_pair_pkg;

    localparam int BYTE_W = 8;
    localparam int PAIR_W = 16;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] a;
        logic [BYTE_W-1:0] b;
    } pair_t;

    typedef enum logic {
        S_A = 1'b0,
        S_B = 1'b1
    } state_t;

    // ab holds {a, b}; a occupies the upper byte.
    function automatic pair_t make_pair(input logic last, input logic [PAIR_W-1:0] ab);
        pair_t p;
        p.last = last;
        p.a    = ab[PAIR_W-1:BYTE_W];
        p.b    = ab[BYTE_W-1:0];
        return p;
    endfunction

endpackage

// File: rtl/byte_pair_fifo.sv
// rtl/byte_pair_fifo.sv - first-word-fall-through FIFO of byte pairs
// Purpose: DEPTH-entry pair FIFO; head is held in a register so it keeps
//          the last-read entry while the FIFO is empty.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data (ignored when full)
//   push_data   entry to write
//   pop         drop the head entry (ignored when empty)
//   head        current head entry (last-read entry when empty)
//   full        occupancy == DEPTH
//   empty       occupancy == 0
//   level       current occupancy
module byte_pair_fifo
    import byte_pair_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  pair_t                  push_data,
    input  logic                   pop,
    output pair_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    pair_t            r_mem [DEPTH];
    pair_t            r_head;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_next;
    logic [PTR_W:0]   w_count_next;
    pair_t            w_head_next;

    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign level = r_count;
    assign head  = r_head;

    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for a push.
    assign w_push    = push & ~full;
    assign w_pop     = pop & ~empty;
    assign w_rd_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // When the next head slot is the one being written this cycle, bypass
    // the memory so the new entry is visible right after the push edge.
    assign w_head_next = (w_push && (w_rd_next == r_wr_ptr)) ? push_data : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            if (w_count_next != '0) begin
                r_head <= w_head_next;
            end
        end
    end

endmodule

// File: rtl/byte_pair_packer.sv
// rtl/byte_pair_packer.sv - packs a byte stream into (a,b) pairs behind a FIFO
// Purpose: first accepted byte of a pair is a, second is b; in_last on an a
//          byte closes the packet with b = PAD_BYTE. Optional statistics
//          counters are enabled by defining BYTE_PAIR_STATS_EN.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready   byte input handshake
//   pair_a/pair_b/pair_last             FIFO head entry
//   pair_valid/pair_ready               pair output handshake
//   level            FIFO occupancy
//   pair_cnt/pad_cnt (BYTE_PAIR_STATS_EN) saturating push / padded-push counts
module byte_pair_packer
    import byte_pair_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [7:0]             pair_a,
    output logic [7:0]             pair_b,
    output logic                   pair_last,
    output logic                   pair_valid,
    input  logic                   pair_ready,
    output logic [$clog2(DEPTH):0] level
`ifdef BYTE_PAIR_STATS_EN
    ,
    output logic [15:0]            pair_cnt,
    output logic [15:0]            pad_cnt
`endif
);

    state_t      r_state;
    logic [7:0]  r_hold_a;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    pair_t       w_push_word;
    pair_t       w_head;

    // Ready depends only on registered occupancy, never on pair_ready.
    assign in_ready = ~w_full;
    assign w_accept = in_valid & ~w_full;

    // A push happens on every b byte, and on an a byte that ends a packet.
    assign w_push      = w_accept & ((r_state == S_B) | in_last);
    assign w_push_word = (r_state == S_B) ? make_pair(in_last, {r_hold_a, in_data})
                                          : make_pair(1'b1, {in_data, PAD_BYTE});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_A;
            r_hold_a <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_A: begin
                    if (!in_last) begin
                        r_hold_a <= in_data;
                        r_state  <= S_B;
                    end
                end
                S_B: r_state <= S_A;
                default: r_state <= S_A;
            endcase
        end
    end

    byte_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_word),
        .pop       (pair_ready),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (level)
    );

    assign pair_a     = w_head.a;
    assign pair_b     = w_head.b;
    assign pair_last  = w_head.last;
    assign pair_valid = ~w_empty;

`ifdef BYTE_PAIR_STATS_EN
    logic [15:0] r_pair_cnt;
    logic [15:0] r_pad_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pair_cnt <= '0;
            r_pad_cnt  <= '0;
        end else if (w_push) begin
            if (r_pair_cnt != 16'hFFFF) begin
                r_pair_cnt <= r_pair_cnt + 1'b1;
            end
            if ((r_state == S_A) && (r_pad_cnt != 16'hFFFF)) begin
                r_pad_cnt <= r_pad_cnt + 1'b1;
            end
        end
    end

    assign pair_cnt = r_pair_cnt;
    assign pad_cnt  = r_pad_cnt;
`endif

endmodule

// File: tb/tb_byte_pair_packer.sv
// tb/tb_byte_pair_packer.sv - directed self-checking bench for byte_pair_packer
module tb_byte_pair_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] pair_a;
    logic [7:0] pair_b;
    logic       pair_last;
    logic       pair_valid;
    logic       pair_ready;
    logic [2:0] level;
`ifdef BYTE_PAIR_STATS_EN
    logic [15:0] pair_cnt;
    logic [15:0] pad_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    byte_pair_packer #(
        .DEPTH    (4),
        .PAD_BYTE (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .pair_a     (pair_a),
        .pair_b     (pair_b),
        .pair_last  (pair_last),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .level      (level)
`ifdef BYTE_PAIR_STATS_EN
        ,
        .pair_cnt   (pair_cnt),
        .pad_cnt    (pad_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = 8'h00;
        pair_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Presents one byte until accepted (bounded), then drops in_valid.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int waited;
        waited = 0;
        in_data = d;
        in_last = l;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        n_tests++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_byte_timeout: byte %h in_ready=%b after %0d cycles, required 1", d, in_ready, waited);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({pair_valid, level, pair_a, pair_b, pair_last, in_ready} !== {1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b level=%0d a=%h b=%h last=%b rdy=%b, required 0 0 00 00 0 1",
                     pair_valid, level, pair_a, pair_b, pair_last, in_ready);
        end
    endtask

    task automatic test_basic_pair();
        pair_ready = 1'b1;
        send_byte(8'h12, 1'b0);
        n_tests++;
        if (pair_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_half_built_valid: got %b, required 0", pair_valid);
        end
        send_byte(8'h34, 1'b1);
        n_tests++;
        if ({pair_valid, pair_a, pair_b, pair_last, level} !== {1'b1, 8'h12, 8'h34, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL basic_pair: valid=%b a=%h b=%h last=%b level=%0d, required 1 12 34 1 1",
                     pair_valid, pair_a, pair_b, pair_last, level);
        end
        tick();
        n_tests++;
        if ({pair_valid, level, pair_a, pair_b} !== {1'b0, 3'd0, 8'h12, 8'h34}) begin
            n_fail++;
            $display("FAIL basic_pop_hold: valid=%b level=%0d a=%h b=%h, required 0 0 12 34",
                     pair_valid, level, pair_a, pair_b);
        end
        pair_ready = 1'b0;
    endtask

    task automatic test_pad();
        pair_ready = 1'b0;
        send_byte(8'hAB, 1'b1);
        n_tests++;
        if ({pair_valid, pair_a, pair_b, pair_last, level} !== {1'b1, 8'hAB, 8'h00, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL pad_pair: valid=%b a=%h b=%h last=%b level=%0d, required 1 ab 00 1 1",
                     pair_valid, pair_a, pair_b, pair_last, level);
        end
        // Still in S_A: another last byte must again be padded, not paired with AB.
        send_byte(8'hC1, 1'b1);
        n_tests++;
        if ({level, pair_a} !== {3'd2, 8'hAB}) begin
            n_fail++;
            $display("FAIL pad_second_level: level=%0d head_a=%h, required 2 ab", level, pair_a);
        end
        pair_ready = 1'b1;
        tick();
        n_tests++;
        if ({pair_valid, pair_a, pair_b, pair_last, level} !== {1'b1, 8'hC1, 8'h00, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL pad_stays_sa: valid=%b a=%h b=%h last=%b level=%0d, required 1 c1 00 1 1",
                     pair_valid, pair_a, pair_b, pair_last, level);
        end
        tick();
        pair_ready = 1'b0;
        n_tests++;
        if ({pair_valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL pad_drain: valid=%b level=%0d, required 0 0", pair_valid, level);
        end
    endtask

    task automatic test_fill();
        pair_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), 1'b0);
        end
        n_tests++;
        if ({level, in_ready, pair_a, pair_b, pair_last} !== {3'd4, 1'b0, 8'h01, 8'h02, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_full: level=%0d rdy=%b a=%h b=%h last=%b, required 4 0 01 02 0",
                     level, in_ready, pair_a, pair_b, pair_last);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [4];
        exp_a = '{8'h03, 8'h05, 8'h07, 8'h09};
        exp_b = '{8'h04, 8'h06, 8'h08, 8'h0A};
        // Push of byte 9 and pop of (1,2) in the same cycle while full.
        in_data = 8'h09;
        in_last = 1'b0;
        in_valid = 1'b1;
        pair_ready = 1'b1;
        tick();
        pair_ready = 1'b0;
        n_tests++;
        if ({level, in_ready, pair_a, pair_b} !== {3'd3, 1'b1, 8'h03, 8'h04}) begin
            n_fail++;
            $display("FAIL full_push_pop: level=%0d rdy=%b a=%h b=%h, required 3 1 03 04",
                     level, in_ready, pair_a, pair_b);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (level !== 3'd3) begin
            n_fail++;
            $display("FAIL refused_push_retry: level=%0d, required 3", level);
        end
        send_byte(8'h0A, 1'b0);
        n_tests++;
        if ({level, in_ready} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL refill: level=%0d rdy=%b, required 4 0", level, in_ready);
        end
        pair_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({pair_valid, pair_a, pair_b, pair_last, level} !== {1'b1, exp_a[i], exp_b[i], 1'b0, 3'(4 - i)}) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: valid=%b a=%h b=%h last=%b level=%0d, required 1 %h %h 0 %0d",
                         i, pair_valid, pair_a, pair_b, pair_last, level, exp_a[i], exp_b[i], 4 - i);
            end
            tick();
        end
        n_tests++;
        if ({pair_valid, level, pair_a, pair_b} !== {1'b0, 3'd0, 8'h09, 8'h0A}) begin
            n_fail++;
            $display("FAIL drain_empty: valid=%b level=%0d a=%h b=%h, required 0 0 09 0a",
                     pair_valid, level, pair_a, pair_b);
        end
        // Pop while empty must be ignored.
        tick();
        pair_ready = 1'b0;
        n_tests++;
        if ({pair_valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL empty_pop: valid=%b level=%0d, required 0 0", pair_valid, level);
        end
    endtask

    task automatic test_reset_mid();
        pair_ready = 1'b0;
        send_byte(8'h55, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({pair_valid, level, pair_a} !== {1'b0, 3'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_state: valid=%b level=%0d a=%h, required 0 0 00", pair_valid, level, pair_a);
        end
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b1);
        n_tests++;
        if ({pair_valid, pair_a, pair_b, pair_last, level} !== {1'b1, 8'h66, 8'h77, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL reset_mid_pair: valid=%b a=%h b=%h last=%b level=%0d, required 1 66 77 1 1",
                     pair_valid, pair_a, pair_b, pair_last, level);
        end
        pair_ready = 1'b1;
        tick();
        pair_ready = 1'b0;
        n_tests++;
        if ({pair_valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_single: valid=%b level=%0d, required 0 0", pair_valid, level);
        end
    endtask

`ifdef BYTE_PAIR_STATS_EN
    task automatic test_stats();
        do_reset();
        pair_ready = 1'b1;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        tick();
        n_tests++;
        if ({pair_cnt, pad_cnt} !== {16'd2, 16'd1}) begin
            n_fail++;
            $display("FAIL stats_counts: pair_cnt=%0d pad_cnt=%0d, required 2 1", pair_cnt, pad_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pair_ready = 1'b0;
        n_tests++;
        if ({pair_cnt, pad_cnt} !== {16'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL stats_reset: pair_cnt=%0d pad_cnt=%0d, required 0 0", pair_cnt, pad_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_pair();
        test_pad();
        test_fill();
        test_full_push_pop();
        test_reset_mid();
`ifdef BYTE_PAIR_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
